// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: field positions, instruction
// classes, per-class operation codes and the control-select bundle.
package isa_pkg;

    localparam int BUS = 32;

    // Instruction field positions
    localparam int FUNTYPE_MSB = 31;
    localparam int FUNTYPE_LSB = 30;
    localparam int FUNCODE_MSB = 29;
    localparam int FUNCODE_LSB = 28;
    localparam int RD_MSB      = 27;
    localparam int RD_LSB      = 24;
    localparam int RA_MSB      = 23;
    localparam int RA_LSB      = 20;
    localparam int RB_MSB      = 19;
    localparam int RB_LSB      = 16;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 1;
    localparam int IMM_SEL_BIT = 0;

    typedef enum logic [1:0] {
        FT_ALU = 2'b00,
        FT_MEM = 2'b01,
        FT_BR  = 2'b10,
        FT_KRN = 2'b11
    } funtype_e;

    // ALU class
    localparam logic [1:0] FC_ADD = 2'b00;
    localparam logic [1:0] FC_SUB = 2'b01;
    localparam logic [1:0] FC_MOV = 2'b10;
    localparam logic [1:0] FC_CMP = 2'b11;
    // Memory class
    localparam logic [1:0] FC_LDR = 2'b00;
    localparam logic [1:0] FC_STR = 2'b01;
    // Branch class
    localparam logic [1:0] FC_B   = 2'b00;
    localparam logic [1:0] FC_BEQ = 2'b01;
    // Kernel class
    localparam logic [1:0] FC_KRN = 2'b00;
    localparam logic [1:0] FC_LKN = 2'b01;
    localparam logic [1:0] FC_LDK = 2'b10;
    localparam logic [1:0] FC_SHK = 2'b11;

    typedef struct packed {
        logic wb;
        logic memrd;
        logic memwr;
        logic cachewr;
        logic cachesh;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [BUS-1:0] sext15(input logic [14:0] imm);
        return {{(BUS-15){imm[14]}}, imm};
    endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Decode-stage bus: fetch/writeback inputs and decoded operands/selects.
interface instruction_decoder_if;
    import isa_pkg::*;

    logic [31:0]    instruction;
    logic [BUS-1:0] WBd;
    logic [BUS-1:0] PCi;
    logic [3:0]     RDwb;
    logic           WE;

    logic [BUS-1:0] OPA;
    logic [BUS-1:0] OPB;
    logic [BUS-1:0] STR_DATA;
    logic [BUS-1:0] PCo;
    logic [BUS-1:0] RKo;
    logic [3:0]     RDo;
    logic [1:0]     FUNTYPE;
    logic [1:0]     FUNCODE;
    logic           selWB;
    logic           selMEMRD;
    logic           selMEMWR;
    logic           selCACHEWR;
    logic           selCACHESH;
    logic           selBRANCH;

    modport master (
        output instruction, WBd, PCi, RDwb, WE,
        input  OPA, OPB, STR_DATA, PCo, RKo, RDo, FUNTYPE, FUNCODE,
               selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH
    );

    modport slave (
        input  instruction, WBd, PCi, RDwb, WE,
        output OPA, OPB, STR_DATA, PCo, RKo, RDo, FUNTYPE, FUNCODE,
               selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH
    );
endinterface

// File: rtl/register_file.sv
// 16 x BUS register file: one write port, three combinational read ports,
// write-through bypass, asynchronous clear that also forces reads to zero.
module register_file
    import isa_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [3:0]     wb_addr,
    input  logic [BUS-1:0] wb_data,
    input  logic [3:0]     ra_addr,
    input  logic [3:0]     rb_addr,
    input  logic [3:0]     rd_addr,
    output logic [BUS-1:0] ra_data,
    output logic [BUS-1:0] rb_data,
    output logic [BUS-1:0] rd_data
);

    logic [BUS-1:0] regs [16];

    // Writeback into the array; cleared asynchronously by rst
    // NOTE: every entry is reset because reads during/after reset must be 0;
    // a storage array normally would not be reset at all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (we) begin
            // NOTE: non-blocking so every reader sees the pre-edge value.
            regs[wb_addr] <= wb_data;
        end
    end

    // Reads forward the in-flight writeback; rst masks both paths to zero
    assign ra_data = rst ? '0 : (we && wb_addr == ra_addr) ? wb_data : regs[ra_addr];
    assign rb_data = rst ? '0 : (we && wb_addr == rb_addr) ? wb_data : regs[rb_addr];
    assign rd_data = rst ? '0 : (we && wb_addr == rd_addr) ? wb_data : regs[rd_addr];

endmodule

// File: rtl/instruction_decoder.sv
// Decode stage: field split, control-select table and operand selection.
module instruction_decoder
    import isa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    instruction_decoder_if.slave  dec
);

    funtype_e       funtype;
    logic [1:0]     funcode;
    logic [3:0]     rd, ra, rb;
    logic [14:0]    imm15;
    logic           imm_sel;
    logic [BUS-1:0] ra_data, rb_data, rd_data;
    ctrl_t          ctrl;

    assign funtype = funtype_e'(dec.instruction[FUNTYPE_MSB:FUNTYPE_LSB]);
    assign funcode = dec.instruction[FUNCODE_MSB:FUNCODE_LSB];
    assign rd      = dec.instruction[RD_MSB:RD_LSB];
    assign ra      = dec.instruction[RA_MSB:RA_LSB];
    assign rb      = dec.instruction[RB_MSB:RB_LSB];
    assign imm15   = dec.instruction[IMM_MSB:IMM_LSB];
    assign imm_sel = dec.instruction[IMM_SEL_BIT];

    register_file u_regs (
        .clk     (clk),
        .rst     (rst),
        .we      (dec.WE),
        .wb_addr (dec.RDwb),
        .wb_data (dec.WBd),
        .ra_addr (ra),
        .rb_addr (rb),
        .rd_addr (rd),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .rd_data (rd_data)
    );

    // Control-select table; reserved encodings fall through to all-zero
    always_comb begin
        // NOTE: default first so no path leaves ctrl unassigned (no latch).
        ctrl = CTRL_NONE;
        unique case (funtype)
            FT_ALU: if (funcode != FC_CMP) ctrl.wb = 1'b1;
            FT_MEM: begin
                if (funcode == FC_LDR) begin
                    ctrl.wb    = 1'b1;
                    ctrl.memrd = 1'b1;
                end else if (funcode == FC_STR) begin
                    ctrl.memwr = 1'b1;
                end
            end
            FT_BR: begin
                if (funcode == FC_B || funcode == FC_BEQ) begin
                    ctrl.wb     = 1'b1;
                    ctrl.branch = 1'b1;
                end
            end
            FT_KRN: begin
                case (funcode)
                    FC_KRN:  ctrl.wb      = 1'b1;
                    FC_LKN:  ctrl.cachewr = 1'b1;
                    FC_LDK:  ctrl.wb      = 1'b1;
                    default: ctrl.cachesh = 1'b1;
                endcase
            end
            default: ctrl = CTRL_NONE;
        endcase
    end

    // Operand selection: branches use PC and the immediate
    assign dec.OPA      = (funtype == FT_BR) ? dec.PCi : ra_data;
    assign dec.OPB      = (imm_sel || funtype == FT_BR) ? sext15(imm15) : rb_data;
    assign dec.STR_DATA = rd_data;
    assign dec.RKo      = rb_data;
    assign dec.PCo      = dec.PCi;
    assign dec.RDo      = rd;
    assign dec.FUNTYPE  = dec.instruction[FUNTYPE_MSB:FUNTYPE_LSB];
    assign dec.FUNCODE  = funcode;

    assign dec.selWB      = ctrl.wb;
    assign dec.selMEMRD   = ctrl.memrd;
    assign dec.selMEMWR   = ctrl.memwr;
    assign dec.selCACHEWR = ctrl.cachewr;
    assign dec.selCACHESH = ctrl.cachesh;
    assign dec.selBRANCH  = ctrl.branch;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder.
module tb_instruction_decoder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    instruction_decoder_if dif ();

    instruction_decoder dut (
        .clk (clk),
        .rst (rst),
        .dec (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH}
    function automatic logic [5:0] sels();
        return {dif.selWB, dif.selMEMRD, dif.selMEMWR,
                dif.selCACHEWR, dif.selCACHESH, dif.selBRANCH};
    endfunction

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        dif.RDwb = addr;
        dif.WBd  = data;
        dif.WE   = 1'b1;
        @(posedge clk);
        #1;
        dif.WE   = 1'b0;
    endtask

    task automatic test_reset();
        dif.instruction = 32'h0080_0000;
        dif.PCi  = 32'h0000_0040;
        dif.WE   = 1'b0;
        dif.RDwb = 4'd0;
        dif.WBd  = '0;
        rst = 1'b1;
        #2;
        checks++;
        if (dif.OPA !== 32'h0) begin
            errors++; $display("FAIL reset_opa: got %h want %h", dif.OPA, 32'h0);
        end
        checks++;
        if (dif.PCo !== 32'h40 || dif.FUNTYPE !== 2'b00 || sels() !== 6'b100000) begin
            errors++; $display("FAIL reset_decode: pco %h ft %b sels %b want 40 00 100000",
                               dif.PCo, dif.FUNTYPE, sels());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_path();
        write_reg(4'd8, 32'd3);
        dif.instruction = 32'h0080_0000;
        #1;
        checks++;
        if (dif.OPA !== 32'd3) begin
            errors++; $display("FAIL write_opa: got %h want %h", dif.OPA, 32'd3);
        end
        // bypass: new value visible before the edge that stores it
        @(negedge clk);
        dif.RDwb = 4'd8;
        dif.WBd  = 32'd7;
        dif.WE   = 1'b1;
        #1;
        checks++;
        if (dif.OPA !== 32'd7) begin
            errors++; $display("FAIL bypass_opa: got %h want %h", dif.OPA, 32'd7);
        end
        dif.WE = 1'b0;
        #1;
        checks++;
        if (dif.OPA !== 32'd3) begin
            errors++; $display("FAIL bypass_no_store: got %h want %h", dif.OPA, 32'd3);
        end
    endtask

    task automatic test_alu();
        logic [31:0] instr [4];
        logic [5:0]  exp_sel [4];
        instr   = '{32'h0112_0000, 32'h1112_0000, 32'h2112_0000, 32'h3112_0000};
        exp_sel = '{6'b100000, 6'b100000, 6'b100000, 6'b000000};
        write_reg(4'd1, 32'hDEAD_BEEF);
        write_reg(4'd2, 32'h0000_1234);
        for (int i = 0; i < 4; i++) begin
            dif.instruction = instr[i];
            #1;
            checks++;
            if (dif.FUNTYPE !== 2'b00 || dif.FUNCODE !== i[1:0] || sels() !== exp_sel[i]) begin
                errors++; $display("FAIL alu_%0d: ft %b fc %b sels %b want 00 %b %b",
                                   i, dif.FUNTYPE, dif.FUNCODE, sels(), i[1:0], exp_sel[i]);
            end
        end
        dif.instruction = 32'h0112_0000;
        #1;
        checks++;
        if (dif.OPA !== 32'hDEAD_BEEF || dif.OPB !== 32'h1234 || dif.RDo !== 4'd1) begin
            errors++; $display("FAIL alu_regs: opa %h opb %h rd %h want deadbeef 1234 1",
                               dif.OPA, dif.OPB, dif.RDo);
        end
        dif.instruction = 32'h0112_0003;
        #1;
        checks++;
        if (dif.OPB !== 32'h1) begin
            errors++; $display("FAIL alu_imm_pos: got %h want %h", dif.OPB, 32'h1);
        end
        dif.instruction = 32'h0112_8001;
        #1;
        checks++;
        if (dif.OPB !== 32'hFFFF_C000) begin
            errors++; $display("FAIL alu_imm_neg: got %h want %h", dif.OPB, 32'hFFFF_C000);
        end
    endtask

    task automatic test_mem();
        dif.instruction = 32'h4112_0000;
        #1;
        checks++;
        if (sels() !== 6'b110000) begin
            errors++; $display("FAIL mem_ldr: sels %b want 110000", sels());
        end
        dif.instruction = 32'h5112_0000;
        #1;
        checks++;
        if (sels() !== 6'b001000 || dif.STR_DATA !== 32'hDEAD_BEEF || dif.RKo !== 32'h1234) begin
            errors++; $display("FAIL mem_str: sels %b str %h rk %h want 001000 deadbeef 1234",
                               sels(), dif.STR_DATA, dif.RKo);
        end
    endtask

    task automatic test_branch();
        dif.PCi = 32'd12;
        dif.instruction = 32'h8112_0000;
        #1;
        checks++;
        if (sels() !== 6'b100001 || dif.OPA !== 32'd12 || dif.OPB !== 32'h0) begin
            errors++; $display("FAIL br_b: sels %b opa %h opb %h want 100001 c 0",
                               sels(), dif.OPA, dif.OPB);
        end
        dif.instruction = 32'h9112_0000;
        #1;
        checks++;
        if (sels() !== 6'b100001 || dif.OPA !== 32'd12 || dif.FUNCODE !== 2'b01) begin
            errors++; $display("FAIL br_beq: sels %b opa %h fc %b want 100001 c 01",
                               sels(), dif.OPA, dif.FUNCODE);
        end
        dif.instruction = 32'h8112_FFFE;
        #1;
        checks++;
        if (dif.OPB !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL br_imm_max: got %h want %h", dif.OPB, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_kernel();
        logic [31:0] instr [4];
        logic [5:0]  exp_sel [4];
        instr   = '{32'hC112_0000, 32'hD112_0000, 32'hE112_0000, 32'hF112_0000};
        exp_sel = '{6'b100000, 6'b000100, 6'b100000, 6'b000010};
        for (int i = 0; i < 4; i++) begin
            dif.instruction = instr[i];
            #1;
            checks++;
            if (sels() !== exp_sel[i] || dif.FUNTYPE !== 2'b11) begin
                errors++; $display("FAIL krn_%0d: sels %b ft %b want %b 11",
                                   i, sels(), dif.FUNTYPE, exp_sel[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        dif.instruction = 32'h0080_0000;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dif.OPA !== 32'h0) begin
            errors++; $display("FAIL rst_mid_opa: got %h want %h", dif.OPA, 32'h0);
        end
        dif.RDwb = 4'd8;
        dif.WBd  = 32'd9;
        dif.WE   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dif.OPA !== 32'h0) begin
            errors++; $display("FAIL rst_blocks_write: got %h want %h", dif.OPA, 32'h0);
        end
        dif.WE = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (dif.OPA !== 32'h0) begin
            errors++; $display("FAIL rst_after_release: got %h want %h", dif.OPA, 32'h0);
        end
    endtask

    task automatic test_reserved();
        logic [31:0] instr [4];
        instr = '{32'h6000_0000, 32'h7112_0000, 32'hA112_0000, 32'hB112_0001};
        for (int i = 0; i < 4; i++) begin
            dif.instruction = instr[i];
            #1;
            checks++;
            if (sels() !== 6'b000000) begin
                errors++; $display("FAIL reserved_%0d: sels %b want 000000", i, sels());
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_path();
        test_alu();
        test_mem();
        test_branch();
        test_kernel();
        test_reset_mid();
        test_reserved();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
